rf_ctx_engine: RTL and testbench

- Context save/restore engine for the RAT MCU register file.
- On SAVE it reads every register through the file's asynchronous read port and writes the contents into a reserved scratch-RAM window.
- On RESTORE it reads that window back and writes each byte into the register file through the write port.
- It sits beside the control unit. During an interrupt entry or exit it takes ownership of the register-file and scratch-RAM ports through muxes driven by BUSY.

---
 rtl/rat_ctx_pkg.sv | 18 +
 rtl/rf_ctx_engine.sv | 114 +++++++++++
 tb/tb_rf_ctx_engine.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rat_ctx_pkg.sv
// Shared types and default sizing for the RAT register-file context engine,
// register file and scratch RAM.
package rat_ctx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_FINISH  = 2'd3
  } ctx_state_e;

  localparam int            CTX_NUM_REGS   = 32;
  localparam int            CTX_DATA_W     = 8;
  localparam int            CTX_RF_ADDR_W  = 5;
  localparam int            CTX_SCR_ADDR_W = 8;
  localparam logic [7:0]    CTX_SAVE_BASE  = 8'hE0;

endpackage

// File: rtl/rf_ctx_engine.sv
// Context save/restore engine: copies the register file into a scratch-RAM
// window on SAVE and back on RESTORE, one register per cycle.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | ports released, waiting for SAVE_START / RESTORE_START
//   ST_SAVE    | RF[idx] -> scratch[SAVE_BASE+idx], one per cycle
//   ST_RESTORE | scratch[SAVE_BASE+idx] -> RF[idx], one per cycle
//   ST_FINISH  | ports released, DONE pulse, back to idle
module rf_ctx_engine
  import rat_ctx_pkg::*;
#(
  parameter int                    NUM_REGS   = CTX_NUM_REGS,
  parameter int                    DATA_W     = CTX_DATA_W,
  parameter int                    RF_ADDR_W  = CTX_RF_ADDR_W,
  parameter int                    SCR_ADDR_W = CTX_SCR_ADDR_W,
  parameter logic [SCR_ADDR_W-1:0] SAVE_BASE  = SCR_ADDR_W'(CTX_SAVE_BASE)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SAVE_START,
  input  logic                  RESTORE_START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [RF_ADDR_W-1:0]  RF_ADDR,
  output logic [DATA_W-1:0]     RF_DIN,
  output logic                  RF_WR,
  input  logic [DATA_W-1:0]     RF_DOUT,
  output logic [SCR_ADDR_W-1:0] SCR_ADDR,
  output logic [DATA_W-1:0]     SCR_DATA_OUT,
  output logic                  SCR_WE,
  input  logic [DATA_W-1:0]     SCR_DATA_IN
);

  // One spare bit keeps the terminal compare from aliasing with index 0.
  localparam int               IDX_W    = $clog2(NUM_REGS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  if (NUM_REGS < 1 || NUM_REGS > (1 << RF_ADDR_W)) begin : g_bad_num_regs
    $error("rf_ctx_engine: NUM_REGS must be in 1..2**RF_ADDR_W");
  end

  ctx_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (SAVE_START)         state_d = ST_SAVE;
        else if (RESTORE_START) state_d = ST_RESTORE;
      end
      ST_SAVE, ST_RESTORE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_FINISH;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs decode only registered state so a reset drops them at once.
  always_comb begin
    BUSY         = 1'b0;
    DONE         = 1'b0;
    RF_ADDR      = '0;
    RF_DIN       = '0;
    RF_WR        = 1'b0;
    SCR_ADDR     = '0;
    SCR_DATA_OUT = '0;
    SCR_WE       = 1'b0;
    case (state_q)
      ST_SAVE: begin
        BUSY         = 1'b1;
        RF_ADDR      = RF_ADDR_W'(idx_q);
        SCR_ADDR     = SAVE_BASE + SCR_ADDR_W'(idx_q);
        SCR_DATA_OUT = RF_DOUT;
        SCR_WE       = 1'b1;
      end
      ST_RESTORE: begin
        BUSY     = 1'b1;
        RF_ADDR  = RF_ADDR_W'(idx_q);
        SCR_ADDR = SAVE_BASE + SCR_ADDR_W'(idx_q);
        RF_DIN   = SCR_DATA_IN;
        RF_WR    = 1'b1;
      end
      ST_FINISH: DONE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_ctx_engine.sv
// Directed bench for rf_ctx_engine: default 32-register instance plus a
// 4-register instance whose save window wraps past 0xFF.
module tb_rf_ctx_engine;

  logic clk = 1'b0;
  logic rst;
  logic save_start, restore_start, save_start2;

  logic       busy, done, rf_wr, scr_we;
  logic [4:0] rf_addr;
  logic [7:0] rf_din, rf_dout, scr_addr, scr_dout, scr_din;

  logic       busy2, done2, rf_wr2, scr_we2;
  logic [4:0] rf_addr2;
  logic [7:0] rf_din2, rf_dout2, scr_addr2, scr_dout2, scr_din2;

  logic [7:0] rf   [0:31];
  logic [7:0] scr  [0:255];
  logic [7:0] rf2  [0:31];
  logic [7:0] scr2 [0:255];

  int preload_mode = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rf_ctx_engine u_dut (
    .CLK(clk), .RST(rst), .SAVE_START(save_start), .RESTORE_START(restore_start),
    .BUSY(busy), .DONE(done), .RF_ADDR(rf_addr), .RF_DIN(rf_din), .RF_WR(rf_wr),
    .RF_DOUT(rf_dout), .SCR_ADDR(scr_addr), .SCR_DATA_OUT(scr_dout),
    .SCR_WE(scr_we), .SCR_DATA_IN(scr_din)
  );

  rf_ctx_engine #(.NUM_REGS(4), .SAVE_BASE(8'hFE)) u_wrap (
    .CLK(clk), .RST(rst), .SAVE_START(save_start2), .RESTORE_START(1'b0),
    .BUSY(busy2), .DONE(done2), .RF_ADDR(rf_addr2), .RF_DIN(rf_din2), .RF_WR(rf_wr2),
    .RF_DOUT(rf_dout2), .SCR_ADDR(scr_addr2), .SCR_DATA_OUT(scr_dout2),
    .SCR_WE(scr_we2), .SCR_DATA_IN(scr_din2)
  );

  assign rf_dout  = rf[rf_addr];
  assign scr_din  = scr[scr_addr];
  assign rf_dout2 = rf2[rf_addr2];
  assign scr_din2 = scr2[scr_addr2];

  // Memory models; preload_mode loads a pattern in one clock instead of writes.
  always @(posedge clk) begin
    case (preload_mode)
      1: for (int i = 0; i < 32; i++) rf[i] <= 8'(i) ^ 8'h5A;
      2: for (int i = 0; i < 32; i++) begin
           rf[i] <= 8'h00;
           scr[8'hE0 + 8'(i)] <= 8'hA0 + 8'(i);
         end
      3: for (int i = 0; i < 32; i++) begin
           rf[i] <= 8'h11;
           scr[8'hE0 + 8'(i)] <= 8'hA0 + 8'(i);
         end
      4: for (int i = 0; i < 32; i++) rf[i] <= 8'(i) ^ 8'h3C;
      5: begin
           for (int i = 0; i < 32; i++) rf2[i] <= 8'hC0 + 8'(i);
           for (int i = 0; i < 256; i++) scr2[i] <= 8'h00;
         end
      default: begin
        if (scr_we)  scr[scr_addr]   <= scr_dout;
        if (rf_wr)   rf[rf_addr]     <= rf_din;
        if (scr_we2) scr2[scr_addr2] <= scr_dout2;
        if (rf_wr2)  rf2[rf_addr2]   <= rf_din2;
      end
    endcase
  end

  // Per-transfer activity counters, cycle 1 = first cycle after the start edge.
  logic mon_en = 1'b0;
  int mon_cyc, we_cnt, wr_cnt, both_cnt, done_cnt, done_cyc, done_busy, first_we_cyc;
  int first_scr_addr, we2_cnt, done2_cnt, done2_cyc;

  always @(negedge clk) begin
    if (!mon_en) begin
      mon_cyc = 0; we_cnt = 0; wr_cnt = 0; both_cnt = 0; done_cnt = 0;
      done_cyc = -1; done_busy = -1; first_we_cyc = -1; first_scr_addr = -1;
      we2_cnt = 0; done2_cnt = 0; done2_cyc = -1;
    end else begin
      mon_cyc++;
      if (mon_cyc == 1) first_scr_addr = int'(scr_addr);
      if (scr_we) begin
        we_cnt++;
        if (first_we_cyc < 0) first_we_cyc = mon_cyc;
      end
      if (rf_wr) wr_cnt++;
      if (rf_wr && scr_we) both_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc  = mon_cyc;
        done_busy = int'(busy);
      end
      if (scr_we2) we2_cnt++;
      if (done2) begin
        done2_cnt++;
        done2_cyc = mon_cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int mode);
    @(posedge clk); #1 preload_mode = mode;
    @(posedge clk); #1 preload_mode = 0;
  endtask

  task automatic start_xfer(input logic sv, input logic rs, input logic sv2);
    @(posedge clk); #1;
    save_start = sv; restore_start = rs; save_start2 = sv2;
    @(posedge clk); #1;
    save_start = 1'b0; restore_start = 1'b0; save_start2 = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
    #1 mon_en = 1'b0;
  endtask

  task automatic wait_cycle(input int target, input string tag);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (mon_cyc == target) break;
    end
    check(tag, 32'(mon_cyc), 32'(target));
  endtask

  int bad;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    save_start = 1'b0; restore_start = 1'b0; save_start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_strobes", {30'd0, rf_wr, scr_we}, 0);
    check("rst_addr", {19'd0, rf_addr, scr_addr}, 0);
    check("rst_data", {16'd0, rf_din, scr_dout}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", {30'd0, busy, busy2}, 0);

    // Save sweep
    preload(1);
    start_xfer(1'b1, 1'b0, 1'b0);
    run_cycles(40);
    check("save_we_cnt", 32'(we_cnt), 32);
    check("save_first_we", 32'(first_we_cyc), 1);
    check("save_first_addr", 32'(first_scr_addr), 32'hE0);
    check("save_wr_cnt", 32'(wr_cnt), 0);
    check("save_done_cyc", 32'(done_cyc), 33);
    check("save_done_cnt", 32'(done_cnt), 1);
    check("save_done_busy", 32'(done_busy), 0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (scr[8'hE0 + 8'(i)] !== (8'(i) ^ 8'h5A)) bad++;
    check("save_scr_bad", 32'(bad), 0);
    check("save_scr_ff", 32'(scr[8'hFF]), 32'h45);

    // Restore sweep
    preload(2);
    start_xfer(1'b0, 1'b1, 1'b0);
    run_cycles(40);
    check("rest_wr_cnt", 32'(wr_cnt), 32);
    check("rest_we_cnt", 32'(we_cnt), 0);
    check("rest_done_cyc", 32'(done_cyc), 33);
    bad = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== 8'hA0 + 8'(i)) bad++;
    check("rest_rf_bad", 32'(bad), 0);
    check("rest_rf_31", 32'(rf[31]), 32'hBF);

    // Simultaneous start: save wins
    preload(1);
    start_xfer(1'b1, 1'b1, 1'b0);
    run_cycles(45);
    check("both_we_cnt", 32'(we_cnt), 32);
    check("both_wr_cnt", 32'(wr_cnt), 0);
    check("both_done_cnt", 32'(done_cnt), 1);
    check("both_rf3", 32'(rf[3]), 32'h59);

    // Restore request at idx 10 of a save is ignored
    preload(4);
    start_xfer(1'b1, 1'b0, 1'b0);
    wait_cycle(11, "busy_reach_idx10");
    check("busy_addr_idx10", 32'(rf_addr), 10);
    restore_start = 1'b1;
    @(posedge clk); #1 restore_start = 1'b0;
    run_cycles(38);
    check("busy_we_cnt", 32'(we_cnt), 32);
    check("busy_wr_cnt", 32'(wr_cnt), 0);
    check("busy_done_cnt", 32'(done_cnt), 1);
    check("busy_end_idle", 32'(busy), 0);
    check("busy_scr_last", 32'(scr[8'hFF]), 32'h23);

    // Reset in the middle of a restore, at idx 7
    preload(3);
    start_xfer(1'b0, 1'b1, 1'b0);
    wait_cycle(8, "rrst_reach_idx7");
    check("rrst_pre_wr", {27'd0, rf_wr, rf_addr}, 32'h27);
    rst = 1'b1;
    #1;
    check("rrst_busy", 32'(busy), 0);
    check("rrst_wr", 32'(rf_wr), 0);
    check("rrst_done", 32'(done), 0);
    @(posedge clk); #1 rst = 1'b0;
    run_cycles(40);
    check("rrst_no_done", 32'(done_cnt), 0);
    check("rrst_wr_cnt", 32'(wr_cnt), 8);
    check("rrst_idle", 32'(busy), 0);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (rf[i] !== ((i < 7) ? 8'hA0 + 8'(i) : 8'h11)) bad++;
    check("rrst_rf_bad", 32'(bad), 0);

    // Wrapping save window on the 4-register instance
    preload(5);
    start_xfer(1'b0, 1'b0, 1'b1);
    run_cycles(10);
    check("wrap_we_cnt", 32'(we2_cnt), 4);
    check("wrap_done_cyc", 32'(done2_cyc), 5);
    check("wrap_done_cnt", 32'(done2_cnt), 1);
    check("wrap_scr", {scr2[8'hFE], scr2[8'hFF], scr2[8'h00], scr2[8'h01]}, 32'hC0C1C2C3);
    check("wrap_scr_02", 32'(scr2[8'h02]), 0);

    check("never_both_strobes", 32'(both_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
